// File: rtl/cpu_mem_pkg.sv
// Shared definitions for the CPU load/store port and its memory responder.
package cpu_mem_pkg;

  // Responder FSM states.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } mem_state_e;

  localparam int WORD_BYTES      = 4;   // byte lanes per data word
  localparam int BYTE_OFS_W      = 2;   // byte-offset bits inside a word address
  localparam int DEFAULT_LATENCY = 2;   // wait cycles; the CPU stall logic assumes this too
  localparam int LAT_CNT_W       = 4;   // enough for the 1..15 latency range

endpackage

// File: rtl/mem_word_array.sv
// Word-addressed RAM: synchronous byte-enabled write, combinational read, no reset.
module mem_word_array
  import cpu_mem_pkg::*;
#(
  parameter int DEPTH_LOG2 = 8,
  parameter int DATA_W     = 32
) (
  input  logic                  i_clk,
  input  logic                  i_we,
  input  logic [WORD_BYTES-1:0] i_be,
  input  logic [DEPTH_LOG2-1:0] i_waddr,
  input  logic [DATA_W-1:0]     i_wdata,
  input  logic [DEPTH_LOG2-1:0] i_raddr,
  output logic [DATA_W-1:0]     o_rdata
);

  localparam int DEPTH = 1 << DEPTH_LOG2;

  logic [DATA_W-1:0] r_mem [DEPTH];

  // Merge only the enabled byte lanes; disabled lanes keep their old contents.
  always_ff @(posedge i_clk) begin
    if (i_we) begin
      for (int b = 0; b < WORD_BYTES; b++) begin
        if (i_be[b]) r_mem[i_waddr][8*b +: 8] <= i_wdata[8*b +: 8];
      end
    end
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/data_mem_responder.sv
// Load/store responder: accepts one word access, waits LATENCY cycles, then
// returns read data or commits a byte-enabled store, with a one-cycle Ready.
module data_mem_responder
  import cpu_mem_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int DEPTH_LOG2 = 8,
  parameter int LATENCY    = DEFAULT_LATENCY   // legal range 1..15
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_req,
  input  logic                  i_we,
  input  logic [ADDR_W-1:0]     i_addr,
  input  logic [DATA_W-1:0]     i_wdata,
  input  logic [WORD_BYTES-1:0] i_be,
  output logic                  o_ready,
  output logic [DATA_W-1:0]     o_rdata,
  output logic                  o_err,
  output logic                  o_busy
);

  mem_state_e             r_state, w_state_nxt;
  logic [LAT_CNT_W-1:0]   r_cnt, w_cnt_nxt;
  logic                   w_accept;   // request taken this edge
  logic                   w_resolve;  // access completes this edge (entering RESP)

  // Request fields captured at accept; later input changes cannot affect the access.
  logic                   r_we;
  logic [ADDR_W-1:0]      r_addr;
  logic [DATA_W-1:0]      r_wdata;
  logic [WORD_BYTES-1:0]  r_be;

  logic                   r_ready;
  logic                   r_err;
  logic [DATA_W-1:0]      r_rdata;

  logic                   w_misalign;
  logic                   w_oor;
  logic                   w_fault;
  logic                   w_mem_we;
  logic [DEPTH_LOG2-1:0]  w_word_idx;
  logic [DATA_W-1:0]      w_mem_rdata;

  // Fault decode works only on latched fields.
  assign w_misalign = (r_addr[BYTE_OFS_W-1:0] != '0);
  assign w_oor      = ((r_addr >> (DEPTH_LOG2 + BYTE_OFS_W)) != '0);
  assign w_fault    = w_misalign | w_oor;
  assign w_word_idx = r_addr[DEPTH_LOG2+BYTE_OFS_W-1:BYTE_OFS_W];

  // A reset landing on the resolve edge must suppress the write as well.
  assign w_mem_we   = w_resolve & ~i_rst & r_we & ~w_fault;

  // Next-state and counter logic.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_accept    = 1'b0;
    w_resolve   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (i_req) begin
          w_accept    = 1'b1;
          w_cnt_nxt   = LAT_CNT_W'(LATENCY - 1);
          w_state_nxt = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (r_cnt == '0) begin
          w_resolve   = 1'b1;
          w_state_nxt = ST_RESP;
        end else begin
          w_cnt_nxt   = r_cnt - 1'b1;
        end
      end
      ST_RESP: begin
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // State and latency counter registers.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Capture request fields on accept; no reset needed since they are only read after an accept.
  always_ff @(posedge i_clk) begin
    if (w_accept) begin
      r_we    <= i_we;
      r_addr  <= i_addr;
      r_wdata <= i_wdata;
      r_be    <= i_be;
    end
  end

  // Response registers: loaded on the resolve edge, cleared on every other edge.
  always_ff @(posedge i_clk) begin
    if (i_rst || !w_resolve) begin
      r_ready <= 1'b0;
      r_err   <= 1'b0;
      r_rdata <= '0;
    end else begin
      r_ready <= 1'b1;
      r_err   <= w_fault;
      r_rdata <= (!w_fault && !r_we) ? w_mem_rdata : '0;
    end
  end

  mem_word_array #(
    .DEPTH_LOG2 (DEPTH_LOG2),
    .DATA_W     (DATA_W)
  ) u_mem (
    .i_clk   (i_clk),
    .i_we    (w_mem_we),
    .i_be    (r_be),
    .i_waddr (w_word_idx),
    .i_wdata (r_wdata),
    .i_raddr (w_word_idx),
    .o_rdata (w_mem_rdata)
  );

  assign o_ready = r_ready;
  assign o_err   = r_err;
  assign o_rdata = r_rdata;
  assign o_busy  = (r_state != ST_IDLE);

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench: vector table of accesses plus hand sequences for reset abort,
// held request / address toggling, and the LATENCY=1 / LATENCY=15 builds.
module tb_data_mem_responder;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        we  = 1'b0;
  logic [31:0] addr  = '0;
  logic [31:0] wdata = '0;
  logic [3:0]  be    = '0;
  logic        req0 = 1'b0, req1 = 1'b0, req15 = 1'b0;

  logic        rdy0, rdy1, rdy15;
  logic        err0, err1, err15;
  logic        bsy0, bsy1, bsy15;
  logic [31:0] rd0, rd1, rd15;

  int n_pass = 0;
  int n_tot  = 0;

  always #5 clk = ~clk;

  data_mem_responder #(.LATENCY(2)) dut (
    .i_clk(clk), .i_rst(rst), .i_req(req0), .i_we(we), .i_addr(addr), .i_wdata(wdata),
    .i_be(be), .o_ready(rdy0), .o_rdata(rd0), .o_err(err0), .o_busy(bsy0));

  data_mem_responder #(.LATENCY(1)) dut1 (
    .i_clk(clk), .i_rst(rst), .i_req(req1), .i_we(we), .i_addr(addr), .i_wdata(wdata),
    .i_be(be), .o_ready(rdy1), .o_rdata(rd1), .o_err(err1), .o_busy(bsy1));

  data_mem_responder #(.LATENCY(15)) dut15 (
    .i_clk(clk), .i_rst(rst), .i_req(req15), .i_we(we), .i_addr(addr), .i_wdata(wdata),
    .i_be(be), .o_ready(rdy15), .o_rdata(rd15), .o_err(err15), .o_busy(bsy15));

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  function automatic logic get_rdy(input int sel);
    case (sel) 1: return rdy1; 2: return rdy15; default: return rdy0; endcase
  endfunction
  function automatic logic get_bsy(input int sel);
    case (sel) 1: return bsy1; 2: return bsy15; default: return bsy0; endcase
  endfunction
  function automatic logic get_err(input int sel);
    case (sel) 1: return err1; 2: return err15; default: return err0; endcase
  endfunction
  function automatic logic [31:0] get_rd(input int sel);
    case (sel) 1: return rd1; 2: return rd15; default: return rd0; endcase
  endfunction
  function automatic int get_lat(input int sel);
    case (sel) 1: return 1; 2: return 15; default: return 2; endcase
  endfunction

  task automatic set_req(input int sel, input logic v);
    case (sel)
      1: req1 = v;
      2: req15 = v;
      default: req0 = v;
    endcase
  endtask

  // One complete access: checks latency, data, error, single-cycle Ready, Busy span.
  task automatic do_access(input int sel, input logic w, input logic [31:0] a,
                           input logic [31:0] d, input logic [3:0] b,
                           input logic exp_err, input logic [31:0] exp_rd, input string nm);
    int  lat, busy_n;
    bit  seen;
    @(negedge clk);
    we = w; addr = a; wdata = d; be = b;
    set_req(sel, 1'b1);
    lat = -1; busy_n = 0; seen = 0;
    for (int k = 1; k <= 40 && !seen; k++) begin
      @(negedge clk);
      if (get_bsy(sel)) busy_n++;
      if (get_rdy(sel)) begin
        seen = 1;
        lat  = k - 1;
        chk({nm, "_err"},   32'(get_err(sel)), 32'(exp_err));
        chk({nm, "_rdata"}, get_rd(sel), exp_rd);
        set_req(sel, 1'b0);
      end
    end
    if (!seen) set_req(sel, 1'b0);
    chk({nm, "_latency"}, 32'(lat), 32'(get_lat(sel)));
    chk({nm, "_busycyc"}, 32'(busy_n), 32'(get_lat(sel) + 1));
    @(negedge clk);
    chk({nm, "_ready1cyc"}, 32'(get_rdy(sel)), 32'd0);
    chk({nm, "_idle"},      32'(get_bsy(sel)), 32'd0);
  endtask

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic        exp_err;
    logic [31:0] exp_rd;
  } vec_t;

  vec_t vecs[15];

  initial begin
    vecs[0]  = '{1'b1, 32'h0000_0040, 32'hDEADBEEF, 4'hF, 1'b0, 32'h0};
    vecs[1]  = '{1'b0, 32'h0000_0040, 32'h0,        4'h0, 1'b0, 32'hDEADBEEF};
    vecs[2]  = '{1'b1, 32'h0000_0040, 32'h11223344, 4'h5, 1'b0, 32'h0};
    vecs[3]  = '{1'b0, 32'h0000_0040, 32'h0,        4'h0, 1'b0, 32'hDE22BE44};
    vecs[4]  = '{1'b1, 32'h0000_0000, 32'h0BADF00D, 4'hF, 1'b0, 32'h0};
    vecs[5]  = '{1'b0, 32'h0000_0042, 32'h0,        4'h0, 1'b1, 32'h0};
    vecs[6]  = '{1'b1, 32'h0000_0400, 32'hFFFFFFFF, 4'hF, 1'b1, 32'h0};
    vecs[7]  = '{1'b0, 32'h0000_0000, 32'h0,        4'h0, 1'b0, 32'h0BADF00D};
    vecs[8]  = '{1'b1, 32'h0000_0040, 32'hFFFFFFFF, 4'h0, 1'b0, 32'h0};
    vecs[9]  = '{1'b0, 32'h0000_0040, 32'h0,        4'h0, 1'b0, 32'hDE22BE44};
    vecs[10] = '{1'b1, 32'h0000_03FC, 32'h13579BDF, 4'hF, 1'b0, 32'h0};
    vecs[11] = '{1'b0, 32'h0000_03FC, 32'h0,        4'h0, 1'b0, 32'h13579BDF};
    vecs[12] = '{1'b0, 32'h8000_0000, 32'h0,        4'h0, 1'b1, 32'h0};
    vecs[13] = '{1'b1, 32'h0000_0041, 32'h00000000, 4'hF, 1'b1, 32'h0};
    vecs[14] = '{1'b0, 32'h0000_0040, 32'h0,        4'h0, 1'b0, 32'hDE22BE44};

    // Reset state of all builds.
    repeat (3) @(negedge clk);
    chk("rst_ready",  32'(rdy0), 32'd0);
    chk("rst_busy",   32'(bsy0), 32'd0);
    chk("rst_err",    32'(err0), 32'd0);
    chk("rst_rdata",  rd0, 32'd0);
    chk("rst_busy_l1",  32'(bsy1),  32'd0);
    chk("rst_busy_l15", 32'(bsy15), 32'd0);
    rst = 1'b0;

    // Reset mid-WAIT aborts a store.
    do_access(0, 1'b1, 32'h10, 32'hA5A5A5A5, 4'hF, 1'b0, 32'h0, "pre10");
    @(negedge clk);
    we = 1'b1; addr = 32'h10; wdata = 32'h12345678; be = 4'hF; req0 = 1'b1;
    @(negedge clk);
    chk("abort_inwait", 32'(bsy0), 32'd1);
    rst = 1'b1; req0 = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("abort_ready", 32'(rdy0), 32'd0);
    chk("abort_busy",  32'(bsy0), 32'd0);
    chk("abort_err",   32'(err0), 32'd0);
    chk("abort_rdata", rd0, 32'd0);
    do_access(0, 1'b0, 32'h10, 32'h0, 4'h0, 1'b0, 32'hA5A5A5A5, "ld10");

    // Table-driven accesses on the LATENCY=2 build.
    for (int i = 0; i < 15; i++)
      do_access(0, vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].be,
                vecs[i].exp_err, vecs[i].exp_rd, $sformatf("v%0d", i));

    // Req held through RESP; Addr toggled during WAIT.
    @(negedge clk);
    we = 1'b0; addr = 32'h40; req0 = 1'b1;          // accepted at next edge
    @(negedge clk); addr = 32'h0;
    @(negedge clk); addr = 32'h3FC;
    @(negedge clk);
    chk("hold_ready1", 32'(rdy0), 32'd1);
    chk("hold_rdata1", rd0, 32'hDE22BE44);
    @(negedge clk);                                  // first IDLE cycle, Req still high
    chk("hold_idle",   32'(bsy0), 32'd0);
    chk("hold_rdy_lo", 32'(rdy0), 32'd0);
    @(negedge clk);
    chk("hold_accept2", 32'(bsy0), 32'd1);
    req0 = 1'b0;
    @(negedge clk);
    chk("hold_wait2", 32'(rdy0), 32'd0);
    @(negedge clk);
    chk("hold_ready2", 32'(rdy0), 32'd1);
    chk("hold_rdata2", rd0, 32'h13579BDF);
    @(negedge clk);
    chk("hold_done", 32'(bsy0), 32'd0);

    // Extreme latency builds.
    do_access(1, 1'b1, 32'h80, 32'hCAFEF00D, 4'hF, 1'b0, 32'h0, "l1_st");
    do_access(1, 1'b0, 32'h80, 32'h0, 4'h0, 1'b0, 32'hCAFEF00D, "l1_ld");
    do_access(2, 1'b1, 32'h84, 32'h0F1E2D3C, 4'hF, 1'b0, 32'h0, "l15_st");
    do_access(2, 1'b0, 32'h84, 32'h0, 4'h0, 1'b0, 32'h0F1E2D3C, "l15_ld");
    do_access(2, 1'b0, 32'h86, 32'h0, 4'h0, 1'b1, 32'h0, "l15_mis");

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
